uart_per_ctrl: RTL and testbench
================================

// Module: uart_per_ctrl
// PURPOSE
//  openMSP430 peripheral-bus controller that sequences the UART datapath.
//  Exposes CTRL/STATUS/TXBUF/RXBUF/BAUD registers, launches frames on the TX engine through a one-entry holding register,
//  captures RX bytes on completion, and drives baud divisor and interrupts.
//  Sits between the openMSP430 peripheral bus and the uart_tx/uart_rx/uart_speed_select instances.
// PARAMETERS
//  BASE_ADDR     15'h0090   byte base address; must be 16-byte aligned
//  DEC_WD        3          word-offset decode width (8 word slots)
//  BAUD_DEFAULT  16'd5208   reset value of BAUD (50 MHz / 9600)
//  START_TO      4'd15      cycles LAUNCH/WAIT_BUSY waits for tx_busy before aborting to IDLE
// PORTS
//  mclk      in   1   system clock; all logic on rising edge
//  puc_rst   in   1   reset, synchronous, active-high
//  per_addr  in   14  word address
//  per_din   in   16  write data
//  per_en    in   1   access strobe
//  per_we    in   2   byte write enables ([0]=low byte, [1]=high byte); 0 = read
//  per_dout  out  16  read data; 0 when not selected or when writing
//  tx_start  out  1   one-cycle launch pulse to TX engine
//  tx_data   out  8   byte for TX engine; stable from tx_start until FSM returns to IDLE
//  tx_busy   in   1   TX engine frame in progress
//  rx_data   in   8   RX engine byte; valid on falling edge of rx_busy
//  rx_busy   in   1   RX engine frame in progress (rx_int)
//  baud_div  out  16  divisor to speed-select instances (= BAUD register)
//  irq_rx    out  1   RX interrupt
//  irq_tx    out  1   TX interrupt
// BEHAVIOUR
//  Decode
//   sel = per_en & (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]).
//   Offset = per_addr[DEC_WD-1:0].
//   Reads are combinational same cycle. Unused offsets read 0; writes to them are ignored.
//  Registers by word offset; reset values in brackets
//   0 CTRL   [0]  b0 TX_EN, b1 RX_EN, b2 RX_IE, b3 TX_IE; other bits read 0
//   1 STATUS [0]  RO: b0 TX_BUSY (FSM!=IDLE), b1 TX_FULL (hold_full), b2 RX_VALID
//                 W1C: b3 RX_OVR, b4 TX_DROP
//   2 TXBUF       low-byte write loads hold register, sets hold_full; reads 0
//                 write while hold_full: byte dropped, TX_DROP<=1
//   3 RXBUF  [0]  reads {8'h0, rx_byte}; a read clears RX_VALID on that edge
//   4 BAUD   [BAUD_DEFAULT]  per_we byte-lane writes honoured; baud_div = BAUD
//  TX FSM (states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE)
//   IDLE -> LAUNCH when hold_full & TX_EN. On that edge: tx_data<=hold, hold_full<=0, tx_start<=1.
//   LAUNCH: tx_start high exactly 1 cycle; then -> WAIT_BUSY.
//   WAIT_BUSY: -> WAIT_DONE on tx_busy=1; -> IDLE if START_TO cycles elapse without tx_busy.
//   WAIT_DONE: -> IDLE on tx_busy=0.
//   Latency: TXBUF write in cycle k -> tx_start high in cycle k+2.
//   Back-to-back: next launch no earlier than 1 cycle after IDLE is re-entered.
//   Clearing TX_EN mid-frame: current frame completes; a held byte waits until TX_EN=1.
//  RX capture
//   rx_busy is registered; a 1->0 transition with RX_EN=1 latches rx_data and sets RX_VALID.
//   Capture while RX_VALID=1: byte overwritten, RX_OVR<=1.
//   Capture on the same edge as an RXBUF read: new byte latched, RX_VALID stays 1, no OVR; read returns old byte.
//   Edges with RX_EN=0 are ignored.
//  Interrupts (combinational from flops only)
//   irq_rx = RX_IE & RX_VALID
//   irq_tx = TX_IE & TX_EN & ~hold_full
//  W1C: a hardware set and a software clear on the same edge -> flag ends up set.
//  Reset (any cycle, mid-frame included): all registers to reset values, FSM IDLE, hold_full=0, tx_start=0, tx_data=0, irq_*=0.
// TESTING
//  1 Reset, read BAUD at 0x0098 -> 5208; read CTRL, STATUS -> 0; per_dout=0 for unselected address 0x00A0.
//  2 CTRL=0x0001, write TXBUF=0x55 in cycle k -> tx_start=1 only in cycle k+2, tx_data=0x55.
//    Model tx_busy 10 cycles -> STATUS.TX_BUSY reads 0 after fall.
//  3 Write TXBUF 0x11, 0x22, 0x33 back-to-back while busy -> 0x11, 0x22 sent in order; 0x33 dropped, TX_DROP=1.
//    Write 0x0010 to STATUS -> TX_DROP=0.
//  4 RX_EN=1, RX_IE=1: rx_busy falls with rx_data=0xA5 -> RX_VALID=1, irq_rx=1.
//    Second byte 0x5A before read -> RXBUF=0x5A, RX_OVR=1. Read RXBUF -> irq_rx=0.
//  5 RXBUF read on the same edge as a capture of 0x3C -> read returns old byte, RX_VALID=1, RX_OVR unchanged.
//  6 tx_busy held 0 after launch -> FSM back to IDLE after 15 cycles.
//    Assert puc_rst during WAIT_DONE -> all outputs reset next edge.

Source files
------------

// File: rtl/uart_per_ctrl.sv
// uart_per_ctrl: openMSP430 peripheral-bus front end for the UART.
// Holds CTRL/STATUS/TXBUF/RXBUF/BAUD, launches TX frames from a one-entry
// holding register, captures RX bytes at the end of each frame, and
// produces the baud divisor and the two interrupt lines.
module uart_per_ctrl #(
  parameter logic [14:0] BASE_ADDR    = 15'h0090,
  parameter int          DEC_WD       = 3,
  parameter logic [15:0] BAUD_DEFAULT = 16'd5208,
  parameter logic [3:0]  START_TO     = 4'd15
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_busy,
  output logic [15:0] baud_div,
  output logic        irq_rx,
  output logic        irq_tx
);

  localparam logic [DEC_WD-1:0] OFF_CTRL   = DEC_WD'(0);
  localparam logic [DEC_WD-1:0] OFF_STATUS = DEC_WD'(1);
  localparam logic [DEC_WD-1:0] OFF_TXBUF  = DEC_WD'(2);
  localparam logic [DEC_WD-1:0] OFF_RXBUF  = DEC_WD'(3);
  localparam logic [DEC_WD-1:0] OFF_BAUD   = DEC_WD'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_state_t;

  // Bus decode
  logic              w_sel;
  logic [DEC_WD-1:0] w_off;
  logic              w_rd;
  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_status_wr;
  logic              w_txbuf_wr;
  logic              w_rxbuf_rd;
  logic              w_baud_wr;
  logic              w_rx_fall;
  logic              w_launch;
  logic [15:0]       w_rdata;
  tx_state_t         w_state_nxt;

  // Architectural state
  logic        r_tx_en;
  logic        r_rx_en;
  logic        r_rx_ie;
  logic        r_tx_ie;
  logic [7:0]  r_hold;
  logic        r_hold_full;
  logic        r_tx_drop;
  logic        r_rx_ovr;
  logic        r_rx_valid;
  logic [7:0]  r_rx_byte;
  logic        r_rx_busy_q;
  logic [15:0] r_baud;
  tx_state_t   r_state;
  logic [3:0]  r_to_cnt;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;

  assign w_sel       = per_en & (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]);
  assign w_off       = per_addr[DEC_WD-1:0];
  assign w_rd        = w_sel & (per_we == 2'b00);
  assign w_wr        = w_sel & (per_we != 2'b00);
  assign w_ctrl_wr   = w_wr & per_we[0] & (w_off == OFF_CTRL);
  assign w_status_wr = w_wr & per_we[0] & (w_off == OFF_STATUS);
  assign w_txbuf_wr  = w_wr & per_we[0] & (w_off == OFF_TXBUF);
  assign w_baud_wr   = w_wr & (w_off == OFF_BAUD);
  assign w_rxbuf_rd  = w_rd & (w_off == OFF_RXBUF);

  // End of an RX frame is the registered busy falling, only while RX is enabled.
  assign w_rx_fall   = r_rx_busy_q & ~rx_busy & r_rx_en;

  // Read mux: combinational, zero unless this block is selected for a read.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rdata = 16'h0000;
    if (w_rd) begin
      case (w_off)
        OFF_CTRL:   w_rdata = {12'h000, r_tx_ie, r_rx_ie, r_rx_en, r_tx_en};
        OFF_STATUS: w_rdata = {11'h000, r_tx_drop, r_rx_ovr, r_rx_valid,
                               r_hold_full, (r_state != S_IDLE)};
        OFF_RXBUF:  w_rdata = {8'h00, r_rx_byte};
        OFF_BAUD:   w_rdata = r_baud;
        default:    w_rdata = 16'h0000;
      endcase
    end
  end

  // TX sequencer next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full && r_tx_en) begin
          w_state_nxt = S_LAUNCH;
          w_launch    = 1'b1;
        end
      end
      S_LAUNCH:    w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_to_cnt == START_TO - 4'd1) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // TX sequencer state, start-timeout counter, launch pulse and data.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_state    <= S_IDLE;
      r_to_cnt   <= 4'd0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= w_launch;
      if (w_launch) begin
        r_tx_data <= r_hold;
      end
      if (r_state != S_WAIT_BUSY) begin
        r_to_cnt <= 4'd0;
      end else begin
        r_to_cnt <= r_to_cnt + 4'd1;
      end
    end
  end

  // Control, baud and TX holding register; a write to a full holder is dropped and flagged.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_tx_en     <= 1'b0;
      r_rx_en     <= 1'b0;
      r_rx_ie     <= 1'b0;
      r_tx_ie     <= 1'b0;
      r_baud      <= BAUD_DEFAULT;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_tx_drop   <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        {r_tx_ie, r_rx_ie, r_rx_en, r_tx_en} <= per_din[3:0];
      end
      if (w_baud_wr && per_we[0]) begin
        r_baud[7:0] <= per_din[7:0];
      end
      if (w_baud_wr && per_we[1]) begin
        r_baud[15:8] <= per_din[15:8];
      end
      // Launch needs a full holder and an accepted write needs an empty one, so they never coincide.
      if (w_txbuf_wr && !r_hold_full) begin
        r_hold      <= per_din[7:0];
        r_hold_full <= 1'b1;
      end else if (w_launch) begin
        r_hold_full <= 1'b0;
      end
      // Hardware set wins over a same-edge write-one-to-clear.
      if (w_txbuf_wr && r_hold_full) begin
        r_tx_drop <= 1'b1;
      end else if (w_status_wr && per_din[4]) begin
        r_tx_drop <= 1'b0;
      end
    end
  end

  // RX capture on the falling edge of the registered rx_busy, with overrun tracking.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_rx_busy_q <= 1'b0;
      r_rx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
    end else begin
      r_rx_busy_q <= rx_busy;
      if (w_rx_fall) begin
        r_rx_byte  <= rx_data;
        r_rx_valid <= 1'b1;
      end else if (w_rxbuf_rd) begin
        r_rx_valid <= 1'b0;
      end
      // A byte read out on the capture edge is not lost, so that case is not an overrun.
      if (w_rx_fall && r_rx_valid && !w_rxbuf_rd) begin
        r_rx_ovr <= 1'b1;
      end else if (w_status_wr && per_din[3]) begin
        r_rx_ovr <= 1'b0;
      end
    end
  end

  assign per_dout = w_rdata;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign baud_div = r_baud;
  assign irq_rx   = r_rx_ie & r_rx_valid;
  assign irq_tx   = r_tx_ie & r_tx_en & ~r_hold_full;

endmodule

// File: tb/tb_uart_per_ctrl.sv
// tb_uart_per_ctrl: directed bench for uart_per_ctrl with a small TX engine model.
module tb_uart_per_ctrl;

  localparam logic [15:0] A_CTRL   = 16'h0090;
  localparam logic [15:0] A_STATUS = 16'h0092;
  localparam logic [15:0] A_TXBUF  = 16'h0094;
  localparam logic [15:0] A_RXBUF  = 16'h0096;
  localparam logic [15:0] A_BAUD   = 16'h0098;
  localparam logic [15:0] A_UNUSED = 16'h009C;
  localparam logic [15:0] A_OTHER  = 16'h00A0;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic [15:0] per_dout;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_busy = 1'b0;
  logic [15:0] baud_div;
  logic        irq_rx;
  logic        irq_tx;

  int n_pass = 0;
  int n_total = 0;

  logic       model_en = 1'b1;
  int         busy_len = 10;
  logic [7:0] sent[$];

  uart_per_ctrl dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_busy  (rx_busy),
    .baud_div (baud_div),
    .irq_rx   (irq_rx),
    .irq_tx   (irq_tx)
  );

  always #5 mclk = ~mclk;

  // TX engine model: on a launch pulse record the byte, then stay busy for busy_len cycles.
  always @(negedge mclk) begin
    if (tx_start && model_en) begin
      sent.push_back(tx_data);
      @(posedge mclk);
      #1 tx_busy = 1'b1;
      repeat (busy_len) @(posedge mclk);
      #1 tx_busy = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus tasks are called 1 time unit after a rising edge and return likewise.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] we);
    per_addr = a[14:1];
    per_din  = d;
    per_we   = we;
    per_en   = 1'b1;
    @(posedge mclk);
    #1;
    per_en   = 1'b0;
    per_we   = 2'b00;
    per_din  = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    per_addr = a[14:1];
    per_we   = 2'b00;
    per_en   = 1'b1;
    @(negedge mclk);
    d = per_dout;
    @(posedge mclk);
    #1;
    per_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] b);
    rx_data = b;
    rx_busy = 1'b1;
    idle(3);
    rx_busy = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    puc_rst = 1'b1;
    idle(3);
    puc_rst = 1'b0;
    @(negedge mclk);
    n_total++;
    if ({tx_start, tx_data, irq_rx, irq_tx} !== 11'h000) $display("FAIL reset_outs: got %h want 000", {tx_start, tx_data, irq_rx, irq_tx});
    else n_pass++;
    n_total++;
    if (baud_div !== 16'd5208) $display("FAIL reset_baud_div: got %0d want 5208", baud_div);
    else n_pass++;
    @(posedge mclk); #1;
    bus_read(A_BAUD, d);
    n_total++;
    if (d !== 16'd5208) $display("FAIL reset_baud_rd: got %0d want 5208", d);
    else n_pass++;
    bus_read(A_CTRL, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL reset_ctrl: got %h want 0000", d);
    else n_pass++;
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL reset_status: got %h want 0000", d);
    else n_pass++;
    bus_read(A_OTHER, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL unselected_rd: got %h want 0000", d);
    else n_pass++;
    bus_write(A_UNUSED, 16'hFFFF, 2'b11);
    bus_read(A_UNUSED, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL unused_offset_rd: got %h want 0000", d);
    else n_pass++;
  endtask

  task automatic test_tx_latency();
    logic [15:0] d;
    bus_write(A_CTRL, 16'h0001, 2'b01);
    bus_write(A_TXBUF, 16'h0055, 2'b01);
    @(negedge mclk);
    n_total++;
    if (tx_start !== 1'b0) $display("FAIL tx_start_k1: got %b want 0", tx_start);
    else n_pass++;
    @(negedge mclk);
    n_total++;
    if ({tx_start, tx_data} !== {1'b1, 8'h55}) $display("FAIL tx_start_k2: got %b/%h want 1/55", tx_start, tx_data);
    else n_pass++;
    @(negedge mclk);
    n_total++;
    if (tx_start !== 1'b0) $display("FAIL tx_start_k3: got %b want 0", tx_start);
    else n_pass++;
    @(posedge mclk); #1;
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0001) $display("FAIL status_busy: got %h want 0001", d);
    else n_pass++;
    idle(15);
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL status_after_fall: got %h want 0000", d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    int base;
    base = sent.size();
    bus_write(A_TXBUF, 16'h0011, 2'b01);
    idle(1);
    bus_write(A_TXBUF, 16'h0022, 2'b01);
    bus_write(A_TXBUF, 16'h0033, 2'b01);
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0013) $display("FAIL status_full_drop: got %h want 0013", d);
    else n_pass++;
    for (int i = 0; i < 200 && sent.size() < base + 2; i++) idle(1);
    idle(30);
    n_total++;
    if (sent.size() !== base + 2) $display("FAIL b2b_count: got %0d want %0d", sent.size() - base, 2);
    else n_pass++;
    if (sent.size() >= base + 2) begin
      n_total++;
      if ({sent[base], sent[base+1]} !== 16'h1122) $display("FAIL b2b_order: got %h%h want 1122", sent[base], sent[base+1]);
      else n_pass++;
    end
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0010) $display("FAIL status_drop: got %h want 0010", d);
    else n_pass++;
    bus_write(A_STATUS, 16'h0010, 2'b01);
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL drop_w1c: got %h want 0000", d);
    else n_pass++;
  endtask

  task automatic test_rx();
    logic [15:0] d;
    bus_write(A_CTRL, 16'h0007, 2'b01);
    rx_frame(8'hA5);
    @(negedge mclk);
    n_total++;
    if (irq_rx !== 1'b1) $display("FAIL irq_rx_set: got %b want 1", irq_rx);
    else n_pass++;
    @(posedge mclk); #1;
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0004) $display("FAIL rx_valid: got %h want 0004", d);
    else n_pass++;
    rx_frame(8'h5A);
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h000C) $display("FAIL rx_ovr: got %h want 000c", d);
    else n_pass++;
    bus_read(A_RXBUF, d);
    n_total++;
    if (d !== 16'h005A) $display("FAIL rxbuf_ovr: got %h want 005a", d);
    else n_pass++;
    @(negedge mclk);
    n_total++;
    if (irq_rx !== 1'b0) $display("FAIL irq_rx_clr: got %b want 0", irq_rx);
    else n_pass++;
    @(posedge mclk); #1;
    bus_write(A_CTRL, 16'h0005, 2'b01);
    rx_frame(8'hEE);
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0008) $display("FAIL rx_disabled: got %h want 0008", d);
    else n_pass++;
    bus_write(A_CTRL, 16'h0007, 2'b01);
  endtask

  task automatic test_rx_read_race();
    logic [15:0] d;
    rx_frame(8'h77);
    rx_data = 8'h3C;
    rx_busy = 1'b1;
    idle(1);
    rx_busy  = 1'b0;
    per_addr = A_RXBUF[14:1];
    per_we   = 2'b00;
    per_en   = 1'b1;
    @(negedge mclk);
    d = per_dout;
    @(posedge mclk); #1;
    per_en = 1'b0;
    n_total++;
    if (d !== 16'h0077) $display("FAIL race_old_byte: got %h want 0077", d);
    else n_pass++;
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h000C) $display("FAIL race_status: got %h want 000c", d);
    else n_pass++;
    bus_read(A_RXBUF, d);
    n_total++;
    if (d !== 16'h003C) $display("FAIL race_new_byte: got %h want 003c", d);
    else n_pass++;
    bus_write(A_STATUS, 16'h0008, 2'b01);
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL ovr_w1c: got %h want 0000", d);
    else n_pass++;
    // Overrun set on the same edge as a software clear must win.
    rx_frame(8'h01);
    rx_data = 8'h02;
    rx_busy = 1'b1;
    idle(1);
    rx_busy = 1'b0;
    bus_write(A_STATUS, 16'h0008, 2'b01);
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h000C) $display("FAIL w1c_set_wins: got %h want 000c", d);
    else n_pass++;
  endtask

  task automatic test_timeout_and_reset();
    logic [15:0] d;
    logic        seen;
    logic [20:0] busy_hist;
    int          n_sent;
    model_en = 1'b0;
    bus_write(A_TXBUF, 16'h0066, 2'b01);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge mclk);
      if (tx_start) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL to_launch: got no tx_start want tx_start");
    else n_pass++;
    per_addr  = A_STATUS[14:1];
    per_we    = 2'b00;
    per_en    = 1'b1;
    busy_hist = '0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge mclk);
      busy_hist[j] = per_dout[0];
    end
    per_en = 1'b0;
    n_total++;
    if ({busy_hist[14], busy_hist[17]} !== 2'b10) $display("FAIL to_return: got %b want 10", {busy_hist[14], busy_hist[17]});
    else n_pass++;
    @(posedge mclk); #1;
    model_en = 1'b1;
    bus_write(A_CTRL, 16'h000F, 2'b01);
    bus_write(A_BAUD, 16'h1234, 2'b11);
    bus_write(A_BAUD, 16'hAB00, 2'b10);
    n_total++;
    if (baud_div !== 16'hAB34) $display("FAIL baud_lanes: got %h want ab34", baud_div);
    else n_pass++;
    bus_write(A_TXBUF, 16'h0099, 2'b01);
    idle(4);
    bus_write(A_TXBUF, 16'h0042, 2'b01);
    n_sent = sent.size();
    @(negedge mclk);
    n_total++;
    if ({tx_data, irq_rx, irq_tx} !== {8'h99, 1'b1, 1'b0}) $display("FAIL pre_reset: got %h/%b/%b want 99/1/0", tx_data, irq_rx, irq_tx);
    else n_pass++;
    @(posedge mclk); #1;
    puc_rst = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    n_total++;
    if ({tx_start, tx_data, irq_rx, irq_tx, baud_div} !== {11'h000, 16'd5208}) $display("FAIL midframe_reset: got %b/%h/%b/%b/%0d want 0/00/0/0/5208", tx_start, tx_data, irq_rx, irq_tx, baud_div);
    else n_pass++;
    @(posedge mclk); #1;
    puc_rst = 1'b0;
    bus_read(A_STATUS, d);
    n_total++;
    if (d !== 16'h0000) $display("FAIL reset_status2: got %h want 0000", d);
    else n_pass++;
    bus_write(A_CTRL, 16'h0001, 2'b01);
    idle(20);
    n_total++;
    if (sent.size() !== n_sent) $display("FAIL hold_cleared: got %0d launches want 0", sent.size() - n_sent);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_latency();
    test_back_to_back();
    test_rx();
    test_rx_read_race();
    test_timeout_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
